// File: rtl/cluster_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_pass_sequencer
//  Brief    : Sequences one cluster-finding event: a load strobe, NUM_PASSES
//             priority-encoder passes, then a held output handshake. Events
//             arriving while busy are dropped and counted.
//  Revision : 1.0  initial release
// ============================================================================
module cluster_pass_sequencer #(
    parameter int NUM_PASSES = 8,
    parameter int CNT_BITS   = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                bx_strobe,
    input  logic                out_ready,
    input  logic                clear_overflow,
    output logic                latch_pulse,
    output logic [2:0]          pass,
    output logic                pass_valid,
    output logic                latch_out,
    output logic                busy,
    output logic                overflow,
    output logic [CNT_BITS-1:0] overflow_cnt,
    output logic [11:0]         seq_cnt
);

    localparam logic [2:0] C_LAST_PASS = 3'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PASS = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_pass;
    logic [2:0]          w_pass_nxt;
    logic                w_event;
    logic                w_transfer;
    logic                w_drop;
    logic                r_overflow;
    logic [CNT_BITS-1:0] r_ovf_cnt;
    logic [11:0]         r_seq_cnt;

    // A new event only exists when it is strobed while enabled
    assign w_event    = bx_strobe & enable;
    assign w_transfer = (r_state == S_DONE) & out_ready;

    // State and pass-index registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_pass  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Next-state logic; the pass index falls back to 0 whenever not passing
    always_comb begin
        w_state_nxt = r_state;
        w_pass_nxt  = 3'd0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_drop      = w_event;
                w_state_nxt = S_PASS;
            end
            S_PASS: begin
                w_drop = w_event;
                if (r_pass == C_LAST_PASS) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_pass_nxt = r_pass + 3'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    // A strobe coincident with the transfer starts the next event back-to-back
                    w_state_nxt = w_event ? S_LOAD : S_IDLE;
                end else begin
                    w_drop = w_event;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sticky drop flag and saturating drop counter; a same-cycle drop wins over clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_ovf_cnt  <= '0;
        end else if (clear_overflow) begin
            r_overflow <= w_drop;
            r_ovf_cnt  <= w_drop ? CNT_BITS'(1) : '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (!(&r_ovf_cnt)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_BITS'(1);
            end
        end
    end

    // Completed-transfer counter, wrapping naturally at 12 bits
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seq_cnt <= 12'd0;
        end else if (w_transfer) begin
            r_seq_cnt <= r_seq_cnt + 12'd1;
        end
    end

    assign latch_pulse  = (r_state == S_LOAD);
    assign pass_valid   = (r_state == S_PASS);
    assign pass         = r_pass;
    assign latch_out    = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign overflow     = r_overflow;
    assign overflow_cnt = r_ovf_cnt;
    assign seq_cnt      = r_seq_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cluster_pass_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cluster_pass_sequencer
//  Brief    : Randomized self-checking bench for cluster_pass_sequencer with
//             an event-age reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cluster_pass_sequencer;

    localparam int NP     = 8;
    localparam int CB     = 8;
    localparam int CNTMAX = (1 << CB) - 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          bx_strobe;
    logic          out_ready;
    logic          clear_overflow;
    logic          latch_pulse;
    logic [2:0]    pass;
    logic          pass_valid;
    logic          latch_out;
    logic          busy;
    logic          overflow;
    logic [CB-1:0] overflow_cnt;
    logic [11:0]   seq_cnt;

    cluster_pass_sequencer #(
        .NUM_PASSES (NP),
        .CNT_BITS   (CB)
    ) u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .bx_strobe      (bx_strobe),
        .out_ready      (out_ready),
        .clear_overflow (clear_overflow),
        .latch_pulse    (latch_pulse),
        .pass           (pass),
        .pass_valid     (pass_valid),
        .latch_out      (latch_out),
        .busy           (busy),
        .overflow       (overflow),
        .overflow_cnt   (overflow_cnt),
        .seq_cnt        (seq_cnt)
    );

    always #3 clock = ~clock;

    // Reference model: an accepted event has an age; age 1 is the load cycle,
    // ages 2..NP+1 are passes, age >= NP+2 is waiting for out_ready.
    int m_busy;
    int m_age;
    int m_ovf;
    int m_cnt;
    int m_seq;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_ovf = 0; m_cnt = 0; m_seq = 0;
    endtask

    // Advance the model by one rising edge using the inputs sampled there
    task automatic model_edge();
        int ev, xfer, accept, drop;
        ev     = (bx_strobe && enable) ? 1 : 0;
        xfer   = (m_busy != 0 && m_age >= NP + 2 && out_ready) ? 1 : 0;
        accept = (ev != 0 && (m_busy == 0 || xfer != 0)) ? 1 : 0;
        drop   = (ev != 0 && accept == 0) ? 1 : 0;
        if (clear_overflow) begin
            m_ovf = drop;
            m_cnt = drop;
        end else if (drop != 0) begin
            m_ovf = 1;
            if (m_cnt < CNTMAX) m_cnt++;
        end
        if (xfer != 0) m_seq = (m_seq + 1) % 4096;
        if (accept != 0) begin
            m_busy = 1; m_age = 1;
        end else if (xfer != 0) begin
            m_busy = 0; m_age = 0;
        end else if (m_busy != 0) begin
            m_age++;
        end
    endtask

    task automatic check_all(input string ctx);
        int e_lp, e_pv, e_ps, e_lo;
        e_lp = (m_busy != 0 && m_age == 1) ? 1 : 0;
        e_pv = (m_busy != 0 && m_age >= 2 && m_age <= NP + 1) ? 1 : 0;
        e_ps = (e_pv != 0) ? m_age - 2 : 0;
        e_lo = (m_busy != 0 && m_age >= NP + 2) ? 1 : 0;
        chk({ctx, ".latch_pulse"},  int'(latch_pulse),  e_lp);
        chk({ctx, ".pass_valid"},   int'(pass_valid),   e_pv);
        chk({ctx, ".pass"},         int'(pass),         e_ps);
        chk({ctx, ".latch_out"},    int'(latch_out),    e_lo);
        chk({ctx, ".busy"},         int'(busy),         m_busy);
        chk({ctx, ".overflow"},     int'(overflow),     m_ovf);
        chk({ctx, ".overflow_cnt"}, int'(overflow_cnt), m_cnt);
        chk({ctx, ".seq_cnt"},      int'(seq_cnt),      m_seq);
    endtask

    task automatic cycle(input string ctx);
        @(posedge clock);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic drive(input int p_stb, input int p_en, input int p_rdy, input int p_clr);
        bx_strobe      = ($urandom_range(0, 99) < p_stb);
        enable         = ($urandom_range(0, 99) < p_en);
        out_ready      = ($urandom_range(0, 99) < p_rdy);
        clear_overflow = ($urandom_range(0, 99) < p_clr);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; bx_strobe = 1'b0;
        out_ready = 1'b0; clear_overflow = 1'b0;
        model_reset();
        #10;
        check_all("reset");

        // Strobe on the first edge after release; single event timing
        bx_strobe = 1'b1; enable = 1'b1; out_ready = 1'b1;
        reset_n = 1'b1;
        cycle("single");
        bx_strobe = 1'b0;
        for (int i = 0; i < 12; i++) cycle("single");

        // Backpressure: hold out_ready low across the wait stage
        bx_strobe = 1'b1;
        cycle("bp");
        bx_strobe = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 14; i++) cycle("bp");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle("bp");

        // Overlap: strobes relative to event start at 0, 4 and 10
        for (int i = 0; i < 16; i++) begin
            bx_strobe = (i == 0 || i == 4 || i == 10);
            cycle("overlap");
        end
        bx_strobe = 1'b0;

        // Saturation: continuous drops with the output stalled, then clear with a drop
        bx_strobe = 1'b1; enable = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 310; i++) cycle("sat");
        chk("sat.cnt_at_max", int'(overflow_cnt), CNTMAX);
        clear_overflow = 1'b1;
        cycle("clr_drop");
        chk("clr_drop.cnt_one", int'(overflow_cnt), 1);
        clear_overflow = 1'b0; bx_strobe = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle("drain");

        // enable low with strobes: nothing starts, nothing counted
        enable = 1'b0; bx_strobe = 1'b1;
        for (int i = 0; i < 8; i++) cycle("en_low");

        // enable removed mid-sequence does not abort it
        enable = 1'b1;
        cycle("en_mid");
        enable = 1'b0;
        for (int i = 0; i < 12; i++) cycle("en_mid");
        bx_strobe = 1'b0;

        // Asynchronous reset during pass 3
        enable = 1'b1; bx_strobe = 1'b1;
        cycle("rst_mid");
        bx_strobe = 1'b0;
        for (int i = 0; i < 4; i++) cycle("rst_mid");
        chk("rst_mid.pass_before", int'(pass), 3);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clock); #1;
        check_all("in_rst");
        @(negedge clock);
        bx_strobe = 1'b1; enable = 1'b1; out_ready = 1'b1;
        reset_n = 1'b1;
        cycle("post_rst");
        bx_strobe = 1'b0;
        for (int i = 0; i < 12; i++) cycle("post_rst");

        // Randomized phases with differing pressure profiles
        for (int i = 0; i < 1500; i++) begin drive(30, 90, 70, 2);  cycle("rnd_a"); end
        for (int i = 0; i < 1500; i++) begin drive(50, 50, 30, 5);  cycle("rnd_b"); end
        for (int i = 0; i < 1500; i++) begin drive(20, 100, 100, 0); cycle("rnd_c"); end
        // Saturated throughput long enough to wrap seq_cnt
        for (int i = 0; i < 42000; i++) begin drive(100, 100, 100, 1); cycle("rnd_full"); end
        for (int i = 0; i < 1500; i++) begin drive(60, 80, 10, 3);  cycle("rnd_d"); end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cluster_pass_sequencer.md
CLUSTER_PASS_SEQUENCER -- requirements
Module: cluster_pass_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PASSES, default 8, giving the number of encoder passes per event; legal range 2..8.
REQ-002 The block SHALL have parameter CNT_BITS, default 8, giving the width of the overflow counter.
REQ-003 The block SHALL have port clock  input  1  single system clock (160 MHz); all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable  input  1  when low, new bx_strobe events are ignored.
REQ-006 The block SHALL have port bx_strobe  input  1  one-cycle pulse: new vpfs/cnts are ready.
REQ-007 The block SHALL have port out_ready  input  1  downstream accepts the packed cluster set.
REQ-008 The block SHALL have port clear_overflow  input  1  synchronous clear of the overflow status.
REQ-009 The block SHALL have port latch_pulse  output  1  one-cycle load strobe to the truncators and priority encoders.
REQ-010 The block SHALL have port pass  output  3  index of the current encoder pass.
REQ-011 The block SHALL have port pass_valid  output  1  pass is meaningful this cycle.
REQ-012 The block SHALL have port latch_out  output  1  cluster set valid; held until accepted.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 The block SHALL have port overflow  output  1  sticky flag: one or more events dropped.
REQ-015 The block SHALL have port overflow_cnt  output  CNT_BITS  number of dropped events, saturating.
REQ-016 The block SHALL have port seq_cnt  output  12  number of completed transfers, wrapping.

Function
REQ-017 The block SHALL implement FSM states IDLE, LOAD, PASS and DONE, with all outputs registered or decoded from state only (Moore).
REQ-018 IDLE SHALL move to LOAD when bx_strobe=1 and enable=1 are sampled; otherwise it SHALL stay in IDLE.
REQ-019 In LOAD, latch_pulse SHALL be 1 for exactly one cycle, and the FSM SHALL move to PASS with pass=0.
REQ-020 In PASS, pass_valid SHALL be 1 and pass SHALL increment by 1 per cycle from 0 to NUM_PASSES-1; after NUM_PASSES-1 the FSM SHALL move to DONE.
REQ-021 Outside PASS, pass SHALL read 0 and pass_valid SHALL read 0.
REQ-022 In DONE, latch_out SHALL be 1; a transfer occurs in any DONE cycle with out_ready=1.
REQ-023 DONE SHALL be held, with latch_out steady, while out_ready=0.
REQ-024 On a transfer, seq_cnt SHALL increment, wrapping from 4095 to 0.
REQ-025 On a transfer with bx_strobe=1 and enable=1 in the same cycle, the FSM SHALL go directly to LOAD and the event SHALL be accepted, not dropped.
REQ-026 On a transfer with no new event, the FSM SHALL return to IDLE.
REQ-027 Fixed latency SHALL apply: strobe sampled in cycle t gives latch_pulse at t+1, pass 0..NUM_PASSES-1 at t+2..t+NUM_PASSES+1, and latch_out first at t+NUM_PASSES+2.
REQ-028 Throughput under continuous out_ready SHALL be one event per NUM_PASSES+2 cycles.
REQ-029 bx_strobe=1 with enable=1 in LOAD, PASS, or DONE without transfer SHALL be dropped: overflow set to 1 and overflow_cnt incremented, saturating at 2^CNT_BITS-1.
REQ-030 bx_strobe with enable=0 SHALL be ignored and SHALL not count as dropped.
REQ-031 Deasserting enable mid-sequence SHALL not abort the sequence; the sequence SHALL complete through DONE.
REQ-032 clear_overflow SHALL set overflow=0 and overflow_cnt=0.
REQ-033 If clear_overflow and a drop occur in the same cycle, the result SHALL be overflow=1 and overflow_cnt=1.
REQ-034 pass SHALL be declared 3 bits wide regardless of NUM_PASSES; its value SHALL never exceed NUM_PASSES-1.

Reset
REQ-035 On reset_n low, asynchronously: state SHALL be IDLE, latch_pulse=0, pass=0, pass_valid=0, latch_out=0, busy=0, overflow=0, overflow_cnt=0, seq_cnt=0.
REQ-036 Reset asserted mid-sequence SHALL abandon the sequence with no latch_out; in-flight events SHALL not be counted as dropped.
REQ-037 After reset_n deasserts, the first rising edge SHALL sample inputs normally; a bx_strobe on that edge SHALL be accepted.

Verification
REQ-038 Single event, out_ready=1, NUM_PASSES=8: strobe at cycle 0 -> latch_pulse at 1, pass 0..7 at 2..9, latch_out at 10 only, seq_cnt=1, busy 1..10.
REQ-039 Backpressure: out_ready=0 for cycles 10..14, then 1 -> latch_out high cycles 10..15, one transfer, seq_cnt=1.
REQ-040 Overlap: strobes at cycles 0, 4 and 10 with out_ready=1 -> cycle-4 strobe dropped (overflow=1, overflow_cnt=1); cycle-10 strobe accepted with latch_pulse at 11.
REQ-041 Saturation/clear: 300 dropped strobes -> overflow_cnt=255; clear_overflow coincident with a drop -> overflow_cnt=1, overflow=1.
REQ-042 Reset during PASS (pass=3) -> all outputs at reset values immediately; no latch_out; strobe after release follows REQ-038 timing.
REQ-043 enable=0 with strobes -> no latch_pulse and overflow_cnt unchanged; enable dropped during PASS -> sequence still ends with latch_out.
